// File: rtl/ldl_p2ram_fifo.sv
// FWFT FIFO over a simple-dual-port RAM with a registered read and a 2-entry output buffer.
// Optional `level` output is enabled by defining LDL_P2RAM_FIFO_LEVEL_EN.
module ldl_p2ram_fifo #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 10,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 3)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
`ifdef LDL_P2RAM_FIFO_LEVEL_EN
    ,
    output logic [CW-1:0] level
`endif
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] mem_cnt;
    logic [CW-1:0] mem_cnt_n;
    logic          inflight;
    logic [1:0]    obuf_cnt;
    logic [1:0]    obuf_kept;
    logic [DW-1:0] obuf_head;
    logic [DW-1:0] obuf_tail;
    logic [DW-1:0] head_n;
    logic [DW-1:0] tail_n;
    logic [2:0]    pending;
    logic          we;
    logic          re;
    logic          pop;

    assign we      = s_valid & s_ready;
    assign pop     = m_valid & m_ready;
    assign m_valid = (obuf_cnt != 2'd0);
    assign m_data  = obuf_head;

    // Issue a read only if the word will have an obuf slot when it returns.
    assign pending   = 3'(obuf_cnt) + 3'(inflight) - 3'(pop);
    assign re        = (mem_cnt != '0) && (pending < 3'd2);
    assign obuf_kept = obuf_cnt - {1'b0, pop};

    always_comb begin
        mem_cnt_n = mem_cnt;
        case ({we, re})
            2'b10:   mem_cnt_n = mem_cnt + 1'b1;
            2'b01:   mem_cnt_n = mem_cnt - 1'b1;
            default: mem_cnt_n = mem_cnt;
        endcase
    end

    // Pop shifts tail to head; a returning word fills the first free slot.
    always_comb begin
        head_n = obuf_head;
        tail_n = obuf_tail;
        if (pop) begin
            head_n = obuf_tail;
        end
        if (inflight) begin
            if (obuf_kept == 2'd0) begin
                head_n = rdata;
            end else begin
                tail_n = rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wptr] <= s_data;
        end
        if (re) begin
            rdata <= mem[rptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            mem_cnt   <= '0;
            inflight  <= 1'b0;
            obuf_cnt  <= 2'd0;
            obuf_head <= '0;
            obuf_tail <= '0;
            s_ready   <= 1'b0;
        end else begin
            if (we) begin
                wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (re) begin
                rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            end
            mem_cnt   <= mem_cnt_n;
            inflight  <= re;
            obuf_cnt  <= obuf_kept + {1'b0, inflight};
            obuf_head <= head_n;
            obuf_tail <= tail_n;
            s_ready   <= (mem_cnt_n != CW'(DEPTH));
        end
    end

`ifdef LDL_P2RAM_FIFO_LEVEL_EN
    // Internal RAM->obuf transfers do not change the total, only push and pop do.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else begin
            level <= level + CW'(we) - CW'(pop);
        end
    end
`endif

endmodule
